adc_sampler: RTL and testbench
==============================

Name: adc_sampler

Overview:
- Drives the board's 8-bit parallel ADC (ADC0804-style: CS_n / WR_n / RD_n / INTR_n handshake).
- Runs periodic conversions, latches each result, and presents it as a held sample with a sticky ready flag.
- Register-file MMIO maps `sample` to r1 and `adc_ready` to r8; a write to the ack register clears `adc_ready`.
- Replaces the free-running ready counter with a real conversion handshake.

Parameters:
- SAMPLE_DIV, 500: clock cycles between conversion start ticks (min 16).
- WR_PULSE, 4: cycles WR_n is held low to start a conversion (min 1).
- RD_PULSE, 4: cycles RD_n is held low before data is latched (min 1).
- TIMEOUT, 5000: maximum cycles in WAIT for INTR_n before aborting.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- ctrl_reset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = periodic sampling runs.
- adc_db  in  8  ADC parallel data bus.
- adc_intr_n  in  1  ADC end-of-conversion, active low, asynchronous.
- adc_cs_n  out  1  ADC chip select, active low.
- adc_wr_n  out  1  ADC start-conversion strobe, active low.
- adc_rd_n  out  1  ADC output-enable strobe, active low.
- sample  out  8  last successfully read conversion.
- sample_valid  out  1  one-cycle pulse when `sample` updates.
- adc_ready  out  1  sticky; set on a new sample, cleared by `ack`.
- ack  in  1  one-cycle clear of `adc_ready`.
- overrun  out  1  sticky; a new sample arrived while `adc_ready` was still 1.
- timeout_err  out  1  sticky; a conversion timed out.
- clear_err  in  1  clears `overrun` and `timeout_err`.

Behaviour:
- **Reset values:**
  - adc_cs_n = adc_wr_n = adc_rd_n = 1; sample = 0; sample_valid = 0; adc_ready = 0; overrun = 0; timeout_err = 0.
  - FSM = IDLE; all counters = 0; synchroniser flops = 1.
  - Reset mid-conversion: on the next edge all strobes go high and the FSM returns to IDLE; no sample is produced.
- **Divider:**
  - When enable = 1, counts 0..SAMPLE_DIV-1 and wraps.
  - tick = 1 in the cycle the count equals SAMPLE_DIV-1.
  - When enable = 0, the count is held at 0 and there is no tick. A conversion already in flight still completes.
- **Synchroniser:** adc_intr_n passes through a 2-flop synchroniser; intr_s is the second flop.
- **FSM:** IDLE, START, WAIT, READ. All strobe outputs are registered.
- **IDLE:** all strobes high. On tick, go to START on the next edge.
  - A tick arriving while not in IDLE is dropped (no queueing).
- **START:** cs_n = 0 and wr_n = 0 for exactly WR_PULSE cycles, then WAIT.
- **WAIT:**
  - cs_n, wr_n, rd_n are high; a wait counter increments each cycle.
  - intr_s = 0 → READ on the next edge.
  - Counter reaches TIMEOUT-1 with intr_s still 1 → set timeout_err, go to IDLE, leave sample unchanged.
  - If intr_s = 0 on that same cycle, READ wins and no timeout is flagged.
- **READ:**
  - cs_n = 0 and rd_n = 0 for exactly RD_PULSE cycles.
  - adc_db is captured on the final READ cycle's edge. In the following cycle: sample holds the captured value, sample_valid = 1, adc_ready = 1, and the FSM is in IDLE.
  - Strobes are high in that cycle.
- **Latency:** tick to sample_valid = 1 + WR_PULSE + (cycles in WAIT) + RD_PULSE.
  - Cycles in WAIT ≥ 3: synchroniser delay plus the transition.
- **adc_ready / overrun:**
  - If adc_ready = 1 (and ack is not asserted) when a new sample lands, set overrun.
  - ack and a new sample in the same cycle: adc_ready stays 1 and overrun is not set (the ack consumed the old sample).
  - ack with no pending sample has no effect.
- **Errors:**
  - clear_err clears both error flags.
  - If clear_err coincides with a set event in the same cycle, the set wins.
- adc_wr_n and adc_rd_n are never low in the same cycle.

Test Plan:
Common settings for all cases: SAMPLE_DIV = 20, WR_PULSE = 2, RD_PULSE = 3, TIMEOUT = 50.
1. Reset, enable = 1; model pulls intr_n low 5 cycles after wr_n rises, adc_db = 0xA5 → wr_n low 2 cycles, rd_n low 3 cycles, sample = 0xA5, one sample_valid pulse, adc_ready = 1, no error flags.
2. Do not ack; next conversion returns 0x3C → sample = 0x3C, overrun = 1. Then pulse ack, then clear_err → adc_ready = 0, overrun = 0.
3. Ack in the exact cycle a new sample (0x7F) lands → adc_ready = 1, overrun stays 0.
4. Model never asserts intr_n → rd_n never goes low, timeout_err = 1 after 50 WAIT cycles, sample unchanged; the next tick starts a new conversion normally.
5. Assert ctrl_reset during READ (rd_n low) → all strobes 1 on the next edge, sample = 0, adc_ready = 0, FSM = IDLE; the first tick after reset produces a normal conversion.
6. Deassert enable during WAIT → the conversion completes (sample_valid fires once), then no further wr_n pulses for ≥100 cycles. Re-enable → the first wr_n falls 21 cycles later.

Source files
------------

// File: rtl/adc_sampler.sv
// -----------------------------------------------------------------------------
// adc_sampler
//
// Purpose:
//   Drives an ADC0804-style 8-bit parallel ADC through its CS_n / WR_n / RD_n /
//   INTR_n handshake. A free-running divider issues periodic conversion starts.
//   Each successful read is latched into a held sample. The sample is announced
//   with a one-cycle valid pulse and a sticky ready flag. Overrun and timeout
//   conditions are recorded in sticky error flags.
//
// Ports:
//   clock        in   system clock, all logic on the rising edge
//   ctrl_reset   in   synchronous, active-high reset
//   enable       in   1 = periodic sampling runs
//   adc_db       in   [7:0] ADC parallel data bus
//   adc_intr_n   in   ADC end-of-conversion (active low, asynchronous)
//   adc_cs_n     out  ADC chip select (active low)
//   adc_wr_n     out  ADC start-conversion strobe (active low)
//   adc_rd_n     out  ADC output-enable strobe (active low)
//   sample       out  [7:0] last successfully read conversion
//   sample_valid out  one-cycle pulse when sample updates
//   adc_ready    out  sticky; set on a new sample, cleared by ack
//   ack          in   one-cycle clear of adc_ready
//   overrun      out  sticky; new sample arrived while adc_ready was still 1
//   timeout_err  out  sticky; a conversion timed out waiting for INTR_n
//   clear_err    in   clears overrun and timeout_err
// -----------------------------------------------------------------------------
module adc_sampler #(
    parameter int SAMPLE_DIV = 500,
    parameter int WR_PULSE   = 4,
    parameter int RD_PULSE   = 4,
    parameter int TIMEOUT    = 5000
) (
    input  logic       clock,
    input  logic       ctrl_reset,
    input  logic       enable,
    input  logic [7:0] adc_db,
    input  logic       adc_intr_n,
    output logic       adc_cs_n,
    output logic       adc_wr_n,
    output logic       adc_rd_n,
    output logic [7:0] sample,
    output logic       sample_valid,
    output logic       adc_ready,
    input  logic       ack,
    output logic       overrun,
    output logic       timeout_err,
    input  logic       clear_err
);

    localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int MAX_A   = (WR_PULSE > RD_PULSE) ? WR_PULSE : RD_PULSE;
    localparam int CNT_MAX = (MAX_A > TIMEOUT) ? MAX_A : TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_READ  = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [DIV_W-1:0] r_div;
    logic             w_tick;
    logic             w_capture;
    logic             w_timeout;
    logic             r_intr_meta;
    logic             r_intr_s;
    logic             r_cs_n;
    logic             r_wr_n;
    logic             r_rd_n;
    logic [7:0]       r_sample;
    logic             r_valid;
    logic             r_ready;
    logic             r_overrun;
    logic             r_timeout;

    // Tick is only meaningful while enabled; a disabled divider never fires.
    assign w_tick = enable && (r_div == DIV_W'(SAMPLE_DIV - 1));

    // Sample-period divider: wraps at SAMPLE_DIV-1, parked at 0 while disabled.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_div <= '0;
        end else if (!enable) begin
            r_div <= '0;
        end else if (r_div == DIV_W'(SAMPLE_DIV - 1)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    // Two-flop synchroniser for the asynchronous end-of-conversion input.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_intr_meta <= 1'b1;
            r_intr_s    <= 1'b1;
        end else begin
            r_intr_meta <= adc_intr_n;
            r_intr_s    <= r_intr_meta;
        end
    end

    // Next-state logic. r_cnt is shared: pulse width in START/READ, wait time in WAIT.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cnt_nxt = '0;
                if (w_tick) begin
                    w_state_nxt = ST_START;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_START: begin
                if (r_cnt == CNT_W'(WR_PULSE - 1)) begin
                    w_state_nxt = ST_WAIT;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_WAIT: begin
                // INTR is checked before the timeout, so a same-cycle INTR wins.
                if (!r_intr_s) begin
                    w_state_nxt = ST_READ;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_timeout   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_READ: begin
                if (r_cnt == CNT_W'(RD_PULSE - 1)) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                    w_capture   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register plus strobes decoded from the next state, so each strobe is
    // a flop and lines up exactly with the state it belongs to.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_cs_n  <= 1'b1;
            r_wr_n  <= 1'b1;
            r_rd_n  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_cs_n  <= !((w_state_nxt == ST_START) || (w_state_nxt == ST_READ));
            r_wr_n  <= (w_state_nxt != ST_START);
            r_rd_n  <= (w_state_nxt != ST_READ);
        end
    end

    // Sample capture and the sticky ready/overrun/timeout flags.
    // An ack coinciding with a capture consumes the old sample, so no overrun.
    always_ff @(posedge clock) begin
        if (ctrl_reset) begin
            r_sample  <= 8'h00;
            r_valid   <= 1'b0;
            r_ready   <= 1'b0;
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_valid <= w_capture;
            if (w_capture) begin
                r_sample <= adc_db;
            end else begin
                r_sample <= r_sample;
            end
            if (w_capture) begin
                r_ready <= 1'b1;
            end else if (ack) begin
                r_ready <= 1'b0;
            end else begin
                r_ready <= r_ready;
            end
            if (w_capture && r_ready && !ack) begin
                r_overrun <= 1'b1;
            end else if (clear_err) begin
                r_overrun <= 1'b0;
            end else begin
                r_overrun <= r_overrun;
            end
            if (w_timeout) begin
                r_timeout <= 1'b1;
            end else if (clear_err) begin
                r_timeout <= 1'b0;
            end else begin
                r_timeout <= r_timeout;
            end
        end
    end

    assign adc_cs_n     = r_cs_n;
    assign adc_wr_n     = r_wr_n;
    assign adc_rd_n     = r_rd_n;
    assign sample       = r_sample;
    assign sample_valid = r_valid;
    assign adc_ready    = r_ready;
    assign overrun      = r_overrun;
    assign timeout_err  = r_timeout;

endmodule

// File: tb/tb_adc_sampler.sv
// -----------------------------------------------------------------------------
// tb_adc_sampler
//
// Purpose: self-checking bench for adc_sampler with a behavioural ADC0804 model.
// The model drops INTR_n 5 cycles after WR_n rises and releases it on RD_n.
// Expected samples are queued when RD_n falls and compared when sample_valid
// pulses.
// -----------------------------------------------------------------------------
module tb_adc_sampler;

    localparam int SAMPLE_DIV = 20;
    localparam int WR_PULSE   = 2;
    localparam int RD_PULSE   = 3;
    localparam int TIMEOUT    = 50;

    logic       clock = 1'b0;
    logic       ctrl_reset;
    logic       enable;
    logic [7:0] adc_db;
    logic       adc_intr_n;
    logic       adc_cs_n;
    logic       adc_wr_n;
    logic       adc_rd_n;
    logic [7:0] sample;
    logic       sample_valid;
    logic       adc_ready;
    logic       ack;
    logic       overrun;
    logic       timeout_err;
    logic       clear_err;

    adc_sampler #(
        .SAMPLE_DIV(SAMPLE_DIV),
        .WR_PULSE  (WR_PULSE),
        .RD_PULSE  (RD_PULSE),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .clock       (clock),
        .ctrl_reset  (ctrl_reset),
        .enable      (enable),
        .adc_db      (adc_db),
        .adc_intr_n  (adc_intr_n),
        .adc_cs_n    (adc_cs_n),
        .adc_wr_n    (adc_wr_n),
        .adc_rd_n    (adc_rd_n),
        .sample      (sample),
        .sample_valid(sample_valid),
        .adc_ready   (adc_ready),
        .ack         (ack),
        .overrun     (overrun),
        .timeout_err (timeout_err),
        .clear_err   (clear_err)
    );

    // 10 ns clock.
    always #5 clock = ~clock;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q[$];
    int         wr_run = 0, rd_run = 0, last_wr_len = 0, last_rd_len = 0;
    int         valid_cnt = 0, wr_falls = 0, rd_falls = 0;
    logic       prev_wr_n = 1'b1, prev_rd_n = 1'b1, model_prev_wr = 1'b1;
    int         intr_timer = -1;
    bit         no_intr = 1'b0;
    bit         ack_at_land = 1'b0;

    typedef struct {
        logic [7:0] db;
        bit         ack_land;
        bit         exp_ready;
        bit         exp_ovr;
        bit         post_clr;
    } vec_t;
    vec_t vecs[4];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: ADC model reacts just after the rising edge, monitor samples at
    // the falling edge.
    task automatic cycle();
        @(posedge clock);
        #1;
        if (ctrl_reset) begin
            intr_timer = -1;
            adc_intr_n = 1'b1;
        end else begin
            if (!adc_rd_n) begin
                adc_intr_n = 1'b1;
                intr_timer = -1;
            end
            if (intr_timer > 0) begin
                intr_timer--;
                if (intr_timer == 0) begin
                    adc_intr_n = 1'b0;
                    intr_timer = -1;
                end
            end
            if (adc_wr_n && !model_prev_wr && !no_intr) intr_timer = 5;
        end
        model_prev_wr = adc_wr_n;
        @(negedge clock);
        checks++;
        if (!adc_wr_n && !adc_rd_n) begin
            errors++;
            $display("FAIL strobe_overlap: wr_n=%0b rd_n=%0b required not both 0", adc_wr_n, adc_rd_n);
        end
        if (!adc_wr_n) begin
            if (prev_wr_n) wr_falls++;
            wr_run++;
        end else begin
            if (!prev_wr_n) last_wr_len = wr_run;
            wr_run = 0;
        end
        if (!adc_rd_n) begin
            if (prev_rd_n) begin
                rd_falls++;
                exp_q.push_back(adc_db);
            end
            rd_run++;
        end else begin
            if (!prev_rd_n) last_rd_len = rd_run;
            rd_run = 0;
        end
        prev_wr_n = adc_wr_n;
        prev_rd_n = adc_rd_n;
        if (sample_valid === 1'b1) begin
            valid_cnt++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_sample: got 0x%0h with no conversion pending", sample);
            end else begin
                check("sample", {24'h0, sample}, {24'h0, exp_q.pop_front()});
            end
            if (ack_at_land) begin
                ack = 1'b0;
                ack_at_land = 1'b0;
            end
        end
        if (ack_at_land) ack = (rd_run == RD_PULSE);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int start;
        int n;
        start = valid_cnt;
        n = 0;
        while (valid_cnt == start && n < budget) begin
            cycle();
            n++;
        end
        check(name, valid_cnt - start, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int v0;
        int f0;
        ctrl_reset = 1'b1;
        enable     = 1'b0;
        ack        = 1'b0;
        clear_err  = 1'b0;
        adc_intr_n = 1'b1;
        adc_db     = 8'h00;

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h3C, 1'b0, 1'b1, 1'b1, 1'b1};
        vecs[2] = '{8'h11, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h7F, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) cycle();
        check("rst_cs_n", adc_cs_n, 1);
        check("rst_wr_n", adc_wr_n, 1);
        check("rst_rd_n", adc_rd_n, 1);
        check("rst_sample", sample, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_ready", adc_ready, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout_err, 0);
        ctrl_reset = 1'b0;
        enable     = 1'b1;

        // Normal conversions, overrun, ack/clear and ack-at-landing.
        for (int i = 0; i < 4; i++) begin
            adc_db      = vecs[i].db;
            ack_at_land = vecs[i].ack_land;
            wait_valid($sformatf("vec%0d_valid", i), 100);
            check($sformatf("vec%0d_ready", i), adc_ready, vecs[i].exp_ready);
            check($sformatf("vec%0d_overrun", i), overrun, vecs[i].exp_ovr);
            check($sformatf("vec%0d_timeout", i), timeout_err, 0);
            check($sformatf("vec%0d_wr_len", i), last_wr_len, WR_PULSE);
            check($sformatf("vec%0d_rd_len", i), last_rd_len, RD_PULSE);
            check($sformatf("vec%0d_strobes_high", i), {adc_cs_n, adc_wr_n, adc_rd_n}, 3'b111);
            cycle();
            check($sformatf("vec%0d_valid_pulse", i), sample_valid, 0);
            if (vecs[i].post_clr) begin
                ack = 1'b1;
                cycle();
                ack = 1'b0;
                check("ack_clears_ready", adc_ready, 0);
                check("ack_keeps_overrun", overrun, 1);
                clear_err = 1'b1;
                cycle();
                clear_err = 1'b0;
                check("clear_err_overrun", overrun, 0);
                check("clear_err_ready", adc_ready, 0);
            end
        end

        // Timeout: INTR_n never asserted.
        ack = 1'b1;
        cycle();
        ack = 1'b0;
        no_intr = 1'b1;
        adc_db  = 8'hEE;
        v0 = valid_cnt;
        f0 = rd_falls;
        k = 0;
        while (adc_wr_n && k < 40) begin cycle(); k++; end
        k = 0;
        while (!adc_wr_n && k < 10) begin cycle(); k++; end
        k = 0;
        while (!timeout_err && k < 100) begin cycle(); k++; end
        check("timeout_wait_cycles", k, TIMEOUT);
        check("timeout_no_rd", rd_falls - f0, 0);
        check("timeout_no_valid", valid_cnt - v0, 0);
        check("timeout_sample_held", sample, 8'h7F);
        no_intr = 1'b0;
        adc_db  = 8'h5A;
        wait_valid("after_timeout_valid", 100);
        check("after_timeout_ready", adc_ready, 1);
        check("after_timeout_overrun", overrun, 0);
        check("timeout_sticky", timeout_err, 1);
        clear_err = 1'b1;
        cycle();
        clear_err = 1'b0;
        check("clear_timeout", timeout_err, 0);

        // Reset during READ.
        adc_db = 8'hC3;
        k = 0;
        while (adc_rd_n && k < 60) begin cycle(); k++; end
        check("reached_read", adc_rd_n, 0);
        v0 = valid_cnt;
        ctrl_reset = 1'b1;
        cycle();
        check("rreset_strobes", {adc_cs_n, adc_wr_n, adc_rd_n}, 3'b111);
        check("rreset_sample", sample, 0);
        check("rreset_ready", adc_ready, 0);
        check("rreset_valid", sample_valid, 0);
        ctrl_reset = 1'b0;
        exp_q.delete();
        cycle();
        check("rreset_no_sample", valid_cnt - v0, 0);
        adc_db = 8'h96;
        wait_valid("after_reset_valid", 100);
        check("after_reset_ready", adc_ready, 1);
        check("after_reset_rd_len", last_rd_len, RD_PULSE);

        // Disable during WAIT, then re-enable.
        adc_db = 8'h42;
        k = 0;
        while (adc_wr_n && k < 40) begin cycle(); k++; end
        k = 0;
        while (!adc_wr_n && k < 10) begin cycle(); k++; end
        cycle();
        enable = 1'b0;
        v0 = valid_cnt;
        wait_valid("disable_completes", 100);
        f0 = wr_falls;
        repeat (120) cycle();
        check("disable_single_valid", valid_cnt - v0, 1);
        check("disable_no_wr", wr_falls - f0, 0);
        enable = 1'b1;
        adc_db = 8'h24;
        k = 1;
        while (adc_wr_n && k < 100) begin cycle(); k++; end
        check("reenable_wr_delay", k, SAMPLE_DIV + 1);
        wait_valid("reenable_valid", 100);
        repeat (3) cycle();
        check("queue_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
